axil_rd_master: RTL and testbench
=================================

# axil_rd_master

AXI4-Lite read-channel initiator that turns a simple valid/ready request from a core-side client (fetch or load unit) into a single AXI4-Lite AR/R transaction and returns the data, or an error code, on a buffered response port. It sits between the core and the AXI4-Lite interconnect that reaches read-only peripherals such as the CLINT timer. One transaction is outstanding at a time. Alignment is checked locally, and a bus watchdog prevents a hung slave from stalling the core forever.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32
- TIMEOUT, 255, watchdog limit in cycles; 0 disables the watchdog; counter is 8 bits wide
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous and active-high
- req_valid  in  1  client read request
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address
- resp_valid  out  1  response available
- resp_ready  in  1  client consumes the response
- resp_data  out  DATA_W  read data; 0 on any error
- resp_err  out  2  00 OK, 01 misaligned, 10 bus error (rresp != 00), 11 timeout
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_araddr  out  ADDR_W  AR address
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- m_axi_rdata  in  DATA_W  R data
- m_axi_rresp  in  2  R response

## Operation
- **States:** IDLE, AR, R, RESP.
- **Output decode:** all outputs are registered or decoded from state only.
  - req_ready=1 only in IDLE.
  - m_axi_arvalid=1 only in AR.
  - m_axi_rready=1 only in R.
  - resp_valid=1 only in RESP.
- **IDLE:**
  - On req_valid, latch req_addr.
  - If req_addr[1:0] != 0: go to RESP with resp_err=01 and resp_data=0. No bus activity.
  - Otherwise go to AR and clear the watchdog.
- **AR:**
  - m_axi_araddr holds the latched address, stable while arvalid=1.
  - On arready, go to R.
  - arvalid is never withdrawn before the handshake, except on watchdog expiry.
- **R:**
  - On rvalid, capture the response:
    - rresp=00: resp_data=rdata, resp_err=00.
    - rresp!=00: resp_data=0, resp_err=10.
  - Go to RESP.
- **RESP:**
  - resp_data and resp_err stay stable until resp_ready.
  - On resp_ready, go to IDLE.
- **Watchdog (TIMEOUT != 0):**
  - An 8-bit counter increments each cycle in AR or R and is cleared on entry to AR.
  - When the counter equals TIMEOUT with no handshake in that cycle, go to RESP with resp_err=11 and resp_data=0, dropping arvalid/rready.
  - A late rvalid from the abandoned transaction is ignored: rready stays low outside R.
  - A handshake in the expiry cycle wins over the timeout.
- **Reset:**
  - state=IDLE, all outputs 0, latched address 0, resp_data 0, resp_err 00, counter 0.
  - req_ready rises on the first clock edge after reset release.
  - Reset mid-transaction abandons it; no response is produced.

## Timing
- **Minimum latency:** request accepted at edge N, arvalid high in cycle N+1. With arready=1 in N+1 and rvalid=1 in N+2, resp_valid is high in cycle N+3.
- **Misaligned request:** resp_valid high in the cycle after acceptance.
- **Throughput:** at most one request per 4 cycles. req_ready is low from acceptance until the cycle after the resp_ready handshake.
- **Response buffering:** resp_valid may stay high indefinitely; the AXI side is idle meanwhile.
- **Combinational paths:** no combinational path from any input to any output.
- **Watchdog boundary (TIMEOUT=T):** with no handshake, the abort edge is T+1 cycles after entering AR.

## Test plan
- **Basic read:** req_addr=0x0200_BFF8; slave gives arready and then rvalid with rdata=0x1234_5678, rresp=00 -> araddr=0x0200_BFF8, resp_data=0x1234_5678, resp_err=00, resp_valid 3 cycles after acceptance.
- **Back-pressure:**
  - Stimulus: arready delayed 5 cycles, rvalid delayed 3 cycles, resp_ready delayed 4 cycles.
  - Required: arvalid/araddr stable throughout; exactly one AR handshake; response held stable; req_ready low until resp consumed.
- **Misaligned:** req_addr=0x8000_0002 -> no arvalid ever; resp_err=01, resp_data=0 next cycle.
- **Slave error:** rresp=10 with rdata=0xDEAD_BEEF -> resp_err=10, resp_data=0.
- **Timeout:** TIMEOUT=16, arready held low -> arvalid drops and resp_err=11 on the 17th cycle after entering AR. A later rvalid pulse is ignored and the next request proceeds normally.
- **Reset mid-operation:** assert rst while in R -> all outputs 0 immediately (asynchronous); after release, a new request completes normally with no stale response.

Source files
------------

// File: rtl/axil_rd_master_if.sv
// AXI4-Lite read-address and read-data channels as seen by one initiator and one target.
interface axil_rd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_rd_master.sv
// Single-outstanding AXI4-Lite read initiator with local alignment check and bus watchdog.
// Every output is a flop, so no input reaches an output combinationally.
module axil_rd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [1:0]        resp_err_o,
  axil_rd_master_if.master  m_axi
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;
  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam bit         WD_EN     = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              wd_expire;

  assign wd_expire = WD_EN && (cnt_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value first so no path infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      S_IDLE: begin
        // req_ready_q is low only in the first cycle after reset; it comes up on the next edge.
        req_ready_d = 1'b1;
        if (req_ready_q && req_valid_i) begin
          addr_d      = req_addr_i;
          req_ready_d = 1'b0;
          if (req_addr_i[1:0] != 2'b00) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            data_d       = '0;
            err_d        = ERR_MISALIGN;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end

      S_AR: begin
        cnt_d = cnt_q + 8'd1;
        if (m_axi.arready) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (wd_expire) begin
          state_d      = S_RESP;
          arvalid_d    = 1'b0;
          resp_valid_d = 1'b1;
          data_d       = '0;
          err_d        = ERR_TIMEOUT;
        end
      end

      S_R: begin
        cnt_d = cnt_q + 8'd1;
        if (m_axi.rvalid) begin
          state_d      = S_RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          if (m_axi.rresp == 2'b00) begin
            data_d = m_axi.rdata;
            err_d  = ERR_OK;
          end else begin
            data_d = '0;
            err_d  = ERR_BUS;
          end
        end else if (wd_expire) begin
          state_d      = S_RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          data_d       = '0;
          err_d        = ERR_TIMEOUT;
        end
      end

      S_RESP: begin
        if (resp_ready_i) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= ERR_OK;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = data_q;
  assign resp_err_o    = err_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_rd_master.sv
// Directed bench for axil_rd_master: basic read, back-pressure, misalignment, slave error,
// watchdog expiry and asynchronous reset in the middle of a transaction.
module tb_axil_rd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int ar_hs = 0;

  axil_rd_master_if #(.ADDR_W(32), .DATA_W(32)) m_axi ();

  axil_rd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .m_axi        (m_axi.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && m_axi.arvalid && m_axi.arready) ar_hs++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read with a zero-wait slave; the response is checked three cycles after acceptance.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [1:0] rresp, input logic [31:0] exp_data,
                         input logic [1:0] exp_err);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    check({tag, ".arvalid"}, 32'(m_axi.arvalid), 32'd1);
    check({tag, ".araddr"}, m_axi.araddr, addr);
    m_axi.arready = 1'b1;
    tick();
    m_axi.arready = 1'b0;
    check({tag, ".rready"}, 32'(m_axi.rready), 32'd1);
    m_axi.rvalid = 1'b1;
    m_axi.rdata  = rdata;
    m_axi.rresp  = rresp;
    tick();
    m_axi.rvalid = 1'b0;
    m_axi.rresp  = 2'b00;
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".resp_data"}, resp_data, exp_data);
    check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
    check({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int hs0;
    int n;
    m_axi.arready = 1'b0;
    m_axi.rvalid  = 1'b0;
    m_axi.rdata   = '0;
    m_axi.rresp   = 2'b00;

    // Reset state
    #3;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.arvalid", 32'(m_axi.arvalid), 32'd0);
    check("rst.rready", 32'(m_axi.rready), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.araddr", m_axi.araddr, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    #20 rst = 1'b0;
    #1;
    check("rel.req_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("rel.req_ready_high", 32'(req_ready), 32'd1);

    // Basic read
    do_read("basic", 32'h0200_BFF8, 32'h1234_5678, 2'b00, 32'h1234_5678, 2'b00);

    // Back-pressure on every channel
    hs0 = ar_hs;
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.arvalid_hold", 32'(m_axi.arvalid), 32'd1);
      check("bp.araddr_hold", m_axi.araddr, 32'h0000_1000);
      check("bp.req_ready_ar", 32'(req_ready), 32'd0);
      tick();
    end
    m_axi.arready = 1'b1;
    check("bp.arvalid_hs", 32'(m_axi.arvalid), 32'd1);
    tick();
    m_axi.arready = 1'b0;
    check("bp.arvalid_drop", 32'(m_axi.arvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp.rready_hold", 32'(m_axi.rready), 32'd1);
      check("bp.no_resp", 32'(resp_valid), 32'd0);
      tick();
    end
    m_axi.rvalid = 1'b1;
    m_axi.rdata  = 32'hCAFE_F00D;
    tick();
    m_axi.rvalid = 1'b0;
    check("bp.rready_drop", 32'(m_axi.rready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp.resp_valid_hold", 32'(resp_valid), 32'd1);
      check("bp.resp_data_hold", resp_data, 32'hCAFE_F00D);
      check("bp.resp_err_hold", 32'(resp_err), 32'd0);
      check("bp.req_ready_resp", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp.req_ready_back", 32'(req_ready), 32'd1);
    check("bp.ar_handshakes", 32'(ar_hs - hs0), 32'd1);

    // Misaligned request: no bus activity
    hs0 = ar_hs;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0002;
    tick();
    req_valid = 1'b0;
    check("mis.resp_valid", 32'(resp_valid), 32'd1);
    check("mis.resp_err", 32'(resp_err), 32'd1);
    check("mis.resp_data", resp_data, 32'd0);
    check("mis.arvalid", 32'(m_axi.arvalid), 32'd0);
    tick();
    check("mis.arvalid_later", 32'(m_axi.arvalid), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("mis.ar_handshakes", 32'(ar_hs - hs0), 32'd0);

    // Slave error
    do_read("slverr", 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 32'd0, 2'b10);

    // Watchdog: arready never comes
    req_valid = 1'b1;
    req_addr  = 32'h0200_4000;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (m_axi.arvalid && n < 40) begin
      tick();
      n++;
    end
    check("wd.abort_cycle", 32'(n), 32'd17);
    check("wd.resp_valid", 32'(resp_valid), 32'd1);
    check("wd.resp_err", 32'(resp_err), 32'd3);
    check("wd.resp_data", resp_data, 32'd0);
    m_axi.rvalid = 1'b1;
    m_axi.rdata  = 32'h5555_AAAA;
    check("wd.rready_low", 32'(m_axi.rready), 32'd0);
    tick();
    m_axi.rvalid = 1'b0;
    check("wd.err_kept", 32'(resp_err), 32'd3);
    check("wd.data_kept", resp_data, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    do_read("wd_next", 32'h0200_0000, 32'h0BAD_CAFE, 2'b00, 32'h0BAD_CAFE, 2'b00);

    // Asynchronous reset while waiting in R
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    tick();
    req_valid = 1'b0;
    m_axi.arready = 1'b1;
    tick();
    m_axi.arready = 1'b0;
    check("mid.in_r", 32'(m_axi.rready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.rready", 32'(m_axi.rready), 32'd0);
    check("mid.araddr", m_axi.araddr, 32'd0);
    check("mid.resp_data", resp_data, 32'd0);
    check("mid.req_ready", 32'(req_ready), 32'd0);
    #10 rst = 1'b0;
    tick();
    check("mid.req_ready_back", 32'(req_ready), 32'd1);
    check("mid.no_stale_resp", 32'(resp_valid), 32'd0);
    do_read("post_rst", 32'h0000_0044, 32'h7777_1111, 2'b00, 32'h7777_1111, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
